// File: rtl/rx_dec_pkg.sv
// Shared types and constants for the USB4 receive lane decoder.
package rx_dec_pkg;

    typedef enum logic [1:0] {
        GEN4 = 2'd0,
        GEN3 = 2'd1,
        GEN2 = 2'd2
    } gen_speed_e;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam logic [1:0] HDR2_DATA = 2'b01;
    localparam logic [1:0] HDR2_OS   = 2'b10;
    localparam logic [3:0] HDR3_DATA = 4'b0101;
    localparam logic [3:0] HDR3_OS   = 4'b1010;

    localparam int BYTES_GEN2 = 8;
    localparam int BYTES_GEN3 = 16;

    localparam logic [3:0] OS_DSEL = 4'd8;

    function automatic logic [3:0] last_idx(input logic [1:0] gen);
        return (gen == GEN2) ? 4'(BYTES_GEN2 - 1) : 4'(BYTES_GEN3 - 1);
    endfunction

endpackage

// File: rtl/rx_lock_fsm.sv
// Per-lane block-lock tracker, advanced once per accepted block.
// state  | meaning
// HUNT   | counting down consecutive valid headers until lock
// LOCKED | counting down consecutive invalid headers until lock is lost
module rx_lock_fsm
    import rx_dec_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int ERR_THRESH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hdr_strobe,
    input  logic hdr_ok,
    input  logic gen4,
    output logic block_lock
);

    localparam logic [3:0] LOCK_LD = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_LD  = 4'(ERR_THRESH);

    lock_state_e state_q;
    logic [3:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= LOCK_LD;
        end else if (clr) begin
            state_q <= HUNT;
            cnt_q   <= LOCK_LD;
        end else if (hdr_strobe) begin
            case (state_q)
                HUNT: begin
                    if (gen4) begin
                        state_q <= LOCKED;
                        cnt_q   <= ERR_LD;
                    end else if (!hdr_ok) begin
                        cnt_q <= LOCK_LD;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= LOCKED;
                        cnt_q   <= ERR_LD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                LOCKED: begin
                    // Gen4 blocks carry no header, so lock is never lost there
                    if (gen4 || hdr_ok) begin
                        cnt_q <= ERR_LD;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= HUNT;
                        cnt_q   <= LOCK_LD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign block_lock = (state_q == LOCKED);

endmodule

// File: rtl/rx_lane_decoder.sv
// Multi-lane sync-header strip/check, byte serialiser and lock tracking.
// state | meaning
// IDLE  | no block held; ready for a new block
// SHIFT | emitting one byte per lane per cycle from the latched block
module rx_lane_decoder
    import rx_dec_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_THRESH = 8
) (
    input  logic                     enc_clk,
    input  logic                     rst,
    input  logic                     enable_dec,
    input  logic [1:0]               gen_speed,
    input  logic [3:0]               d_sel,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic [NUM_LANES*132-1:0] lane_rx_enc,
    output logic [NUM_LANES*8-1:0]   lane_rx,
    output logic                     byte_valid,
    output logic [3:0]               byte_idx,
    output logic                     data_os,
    output logic [NUM_LANES-1:0]     sync_err,
    output logic [NUM_LANES-1:0]     block_lock,
    output logic                     enable_deskew
);

    logic                   dis;
    logic                   accept;
    logic                   last;
    logic [3:0]             idx_nxt;
    logic                   os_in;
    logic [NUM_LANES-1:0]   hdr_ok;
    logic [127:0]           pay_in [NUM_LANES];

    ser_state_e             state_q;
    logic [1:0]             gen_q;
    logic [3:0]             idx_q;
    logic                   byte_valid_q;
    logic                   blk_ready_q;
    logic                   data_os_q;
    logic                   enable_deskew_q;
    logic [NUM_LANES-1:0]   sync_err_q;
    logic [NUM_LANES*8-1:0] lane_rx_q;
    logic [127:0]           pay_q [NUM_LANES];

    always_comb begin
        dis     = !enable_dec || (gen_speed == 2'b11);
        accept  = !dis && blk_valid && blk_ready_q;
        last    = (idx_q == last_idx(gen_q));
        idx_nxt = idx_q + 4'd1;
        hdr_ok  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            pay_in[l] = '0;
            case (gen_speed)
                GEN2: begin
                    pay_in[l] = {64'b0, lane_rx_enc[l*132+2 +: 64]};
                    hdr_ok[l] = (lane_rx_enc[l*132 +: 2] == HDR2_DATA) ||
                                (lane_rx_enc[l*132 +: 2] == HDR2_OS);
                end
                GEN3: begin
                    pay_in[l] = lane_rx_enc[l*132+4 +: 128];
                    hdr_ok[l] = (lane_rx_enc[l*132 +: 4] == HDR3_DATA) ||
                                (lane_rx_enc[l*132 +: 4] == HDR3_OS);
                end
                default: begin
                    pay_in[l] = lane_rx_enc[l*132 +: 128];
                    hdr_ok[l] = 1'b1;
                end
            endcase
        end
        // Block type follows lane 0; an unrecognised header keeps the last type
        os_in = data_os_q;
        case (gen_speed)
            GEN2: begin
                if (lane_rx_enc[1:0] == HDR2_OS)
                    os_in = 1'b1;
                else if (lane_rx_enc[1:0] == HDR2_DATA)
                    os_in = 1'b0;
            end
            GEN3: begin
                if (lane_rx_enc[3:0] == HDR3_OS)
                    os_in = 1'b1;
                else if (lane_rx_enc[3:0] == HDR3_DATA)
                    os_in = 1'b0;
            end
            default: os_in = (d_sel == OS_DSEL);
        endcase
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            gen_q           <= GEN2;
            idx_q           <= '0;
            byte_valid_q    <= 1'b0;
            blk_ready_q     <= 1'b0;
            data_os_q       <= 1'b0;
            enable_deskew_q <= 1'b0;
            sync_err_q      <= '0;
            lane_rx_q       <= '0;
            for (int l = 0; l < NUM_LANES; l++) pay_q[l] <= '0;
        end else if (dis) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            byte_valid_q    <= 1'b0;
            blk_ready_q     <= 1'b0;
            enable_deskew_q <= 1'b0;
            sync_err_q      <= '0;
            lane_rx_q       <= '0;
        end else begin
            sync_err_q      <= '0;
            enable_deskew_q <= &block_lock;
            if (accept) begin
                state_q      <= SHIFT;
                gen_q        <= gen_speed;
                idx_q        <= '0;
                byte_valid_q <= 1'b1;
                blk_ready_q  <= 1'b0;
                data_os_q    <= os_in;
                sync_err_q   <= ~hdr_ok;
                for (int l = 0; l < NUM_LANES; l++) begin
                    pay_q[l]           <= pay_in[l];
                    lane_rx_q[l*8 +: 8] <= pay_in[l][7:0];
                end
            end else if (state_q == SHIFT && !last) begin
                idx_q       <= idx_nxt;
                blk_ready_q <= (idx_nxt == last_idx(gen_q));
                for (int l = 0; l < NUM_LANES; l++)
                    lane_rx_q[l*8 +: 8] <= pay_q[l][{idx_nxt, 3'b000} +: 8];
            end else begin
                state_q      <= IDLE;
                byte_valid_q <= 1'b0;
                blk_ready_q  <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lock
        rx_lock_fsm #(
            .LOCK_CNT   (LOCK_CNT),
            .ERR_THRESH (ERR_THRESH)
        ) u_lock (
            .clk        (enc_clk),
            .rst_n      (rst),
            .clr        (dis),
            .hdr_strobe (accept),
            .hdr_ok     (hdr_ok[g]),
            .gen4       (gen_speed == GEN4),
            .block_lock (block_lock[g])
        );
    end

    assign blk_ready     = blk_ready_q;
    assign lane_rx       = lane_rx_q;
    assign byte_valid    = byte_valid_q;
    assign byte_idx      = idx_q;
    assign data_os       = data_os_q;
    assign sync_err      = sync_err_q;
    assign enable_deskew = enable_deskew_q;

endmodule

// File: tb/tb_rx_lane_decoder.sv
// Directed bench for rx_lane_decoder with two lanes.
module tb_rx_lane_decoder;

    localparam int NL = 2;

    logic            enc_clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable_dec = 1'b1;
    logic [1:0]      gen_speed = 2'd2;
    logic [3:0]      d_sel = 4'd0;
    logic            blk_valid = 1'b0;
    logic            blk_ready;
    logic [NL*132-1:0] lane_rx_enc = '0;
    logic [NL*8-1:0] lane_rx;
    logic            byte_valid;
    logic [3:0]      byte_idx;
    logic            data_os;
    logic [NL-1:0]   sync_err;
    logic [NL-1:0]   block_lock;
    logic            enable_deskew;

    int total = 0;
    int bad = 0;

    rx_lane_decoder #(.NUM_LANES(NL), .LOCK_CNT(4), .ERR_THRESH(8)) dut (
        .enc_clk(enc_clk), .rst(rst), .enable_dec(enable_dec), .gen_speed(gen_speed),
        .d_sel(d_sel), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .lane_rx_enc(lane_rx_enc), .lane_rx(lane_rx), .byte_valid(byte_valid),
        .byte_idx(byte_idx), .data_os(data_os), .sync_err(sync_err),
        .block_lock(block_lock), .enable_deskew(enable_deskew)
    );

    always #5 enc_clk = ~enc_clk;

    function automatic logic [131:0] mk2(input logic [1:0] hdr, input logic [7:0] base);
        logic [131:0] v;
        v = '1;
        v[1:0] = hdr;
        for (int k = 0; k < 8; k++) v[2+8*k +: 8] = base + 8'(k);
        return v;
    endfunction

    function automatic logic [131:0] mk3(input logic [3:0] hdr, input logic [7:0] base);
        logic [131:0] v;
        v[3:0] = hdr;
        for (int k = 0; k < 16; k++) v[4+8*k +: 8] = base + 8'(k);
        return v;
    endfunction

    function automatic logic [131:0] mk4(input logic [3:0] top, input logic [7:0] base);
        logic [131:0] v;
        v[131:128] = top;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(k);
        return v;
    endfunction

    // Drives one block at a ready edge and returns on its last byte.
    task automatic send_blk(input logic [131:0] e0, input logic [131:0] e1, input int nbytes);
        lane_rx_enc = {e1, e0};
        blk_valid = 1'b1;
        @(negedge enc_clk);
        blk_valid = 1'b0;
        repeat (nbytes - 1) @(negedge enc_clk);
    endtask

    task automatic change_gen(input logic [1:0] g);
        enable_dec = 1'b0;
        gen_speed = g;
        @(negedge enc_clk);
        enable_dec = 1'b1;
        @(negedge enc_clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge enc_clk);
        total++;
        if ({lane_rx, byte_valid, byte_idx, data_os, sync_err, block_lock, enable_deskew, blk_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got lane_rx=%h bv=%b idx=%0d os=%b se=%b bl=%b ed=%b rdy=%b exp all zero",
                     lane_rx, byte_valid, byte_idx, data_os, sync_err, block_lock, enable_deskew, blk_ready);
        end
        rst = 1'b1;
        @(negedge enc_clk);
        total++;
        if (blk_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", blk_ready);
        end
    endtask

    task automatic test_gen2_lock;
        logic [15:0] exp_rx;
        for (int b = 0; b < 4; b++) begin
            lane_rx_enc = {mk2(2'b01, 8'h10), mk2(2'b01, 8'h00)};
            blk_valid = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge enc_clk);
                blk_valid = 1'b0;
                exp_rx = {8'h10 + 8'(k), 8'(k)};
                total++;
                if (byte_valid !== 1'b1 || byte_idx !== 4'(k) || lane_rx !== exp_rx || data_os !== 1'b0) begin
                    bad++;
                    $display("FAIL gen2_byte b=%0d k=%0d got bv=%b idx=%0d rx=%h os=%b exp bv=1 idx=%0d rx=%h os=0",
                             b, k, byte_valid, byte_idx, lane_rx, data_os, k, exp_rx);
                end
                if (k == 0) begin
                    total++;
                    if (block_lock !== ((b == 3) ? 2'b11 : 2'b00) || sync_err !== 2'b00) begin
                        bad++;
                        $display("FAIL gen2_lock b=%0d got bl=%b se=%b exp bl=%b se=00",
                                 b, block_lock, sync_err, (b == 3) ? 2'b11 : 2'b00);
                    end
                end
                if (k == 1) begin
                    total++;
                    if (enable_deskew !== (b == 3)) begin
                        bad++;
                        $display("FAIL gen2_deskew b=%0d got=%b exp=%b", b, enable_deskew, b == 3);
                    end
                end
            end
            @(negedge enc_clk);
        end
        total++;
        if (byte_valid !== 1'b0 || blk_ready !== 1'b1) begin
            bad++;
            $display("FAIL gen2_idle got bv=%b rdy=%b exp bv=0 rdy=1", byte_valid, blk_ready);
        end
    endtask

    task automatic test_gen3_b2b;
        logic [15:0] exp_rx;
        logic [7:0]  b0;
        logic [7:0]  b1;
        change_gen(2'd1);
        lane_rx_enc = {mk3(4'b1010, 8'h40), mk3(4'b1010, 8'h20)};
        blk_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge enc_clk);
            if (k == 0) lane_rx_enc = {mk3(4'b0101, 8'h50), mk3(4'b0101, 8'h30)};
            if (k == 16) blk_valid = 1'b0;
            b0 = (k < 16) ? 8'h20 : 8'h30;
            b1 = (k < 16) ? 8'h40 : 8'h50;
            exp_rx = {b1 + 8'(k % 16), b0 + 8'(k % 16)};
            total++;
            if (byte_valid !== 1'b1 || byte_idx !== 4'(k % 16) || lane_rx !== exp_rx ||
                data_os !== (k < 16) || blk_ready !== ((k % 16) == 15)) begin
                bad++;
                $display("FAIL gen3_b2b k=%0d got bv=%b idx=%0d rx=%h os=%b rdy=%b exp bv=1 idx=%0d rx=%h os=%b rdy=%b",
                         k, byte_valid, byte_idx, lane_rx, data_os, blk_ready, k % 16, exp_rx, k < 16, (k % 16) == 15);
            end
        end
        @(negedge enc_clk);
        total++;
        if (byte_valid !== 1'b0) begin
            bad++;
            $display("FAIL gen3_b2b_end got bv=%b exp=0", byte_valid);
        end
    endtask

    task automatic test_gen3_lose_lock;
        send_blk(mk3(4'b0101, 8'h00), mk3(4'b0101, 8'h80), 16);
        send_blk(mk3(4'b0101, 8'h00), mk3(4'b0101, 8'h80), 16);
        total++;
        if (block_lock !== 2'b11 || enable_deskew !== 1'b1) begin
            bad++;
            $display("FAIL gen3_locked got bl=%b ed=%b exp bl=11 ed=1", block_lock, enable_deskew);
        end
        for (int b = 0; b < 8; b++) begin
            lane_rx_enc = {mk3(4'b0000, 8'h80), mk3(4'b0101, 8'h00)};
            blk_valid = 1'b1;
            @(negedge enc_clk);
            blk_valid = 1'b0;
            total++;
            if (sync_err !== 2'b10 || block_lock !== ((b == 7) ? 2'b01 : 2'b11)) begin
                bad++;
                $display("FAIL gen3_syncerr b=%0d got se=%b bl=%b exp se=10 bl=%b",
                         b, sync_err, block_lock, (b == 7) ? 2'b01 : 2'b11);
            end
            @(negedge enc_clk);
            total++;
            if (sync_err !== 2'b00 || enable_deskew !== (b != 7)) begin
                bad++;
                $display("FAIL gen3_pulse_deskew b=%0d got se=%b ed=%b exp se=00 ed=%b",
                         b, sync_err, enable_deskew, b != 7);
            end
            repeat (14) @(negedge enc_clk);
        end
        @(negedge enc_clk);
    endtask

    task automatic test_gen4;
        logic [15:0] exp_rx;
        logic [7:0]  b0;
        logic [7:0]  b1;
        d_sel = 4'd8;
        change_gen(2'd0);
        lane_rx_enc = {mk4(4'hA, 8'h60), mk4(4'hF, 8'h50)};
        blk_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge enc_clk);
            if (k == 0) begin
                d_sel = 4'd3;
                lane_rx_enc = {mk4(4'hC, 8'h90), mk4(4'h5, 8'h70)};
            end
            if (k == 16) blk_valid = 1'b0;
            b0 = (k < 16) ? 8'h50 : 8'h70;
            b1 = (k < 16) ? 8'h60 : 8'h90;
            exp_rx = {b1 + 8'(k % 16), b0 + 8'(k % 16)};
            total++;
            if (byte_valid !== 1'b1 || byte_idx !== 4'(k % 16) || lane_rx !== exp_rx || data_os !== (k < 16)) begin
                bad++;
                $display("FAIL gen4_byte k=%0d got bv=%b idx=%0d rx=%h os=%b exp bv=1 idx=%0d rx=%h os=%b",
                         k, byte_valid, byte_idx, lane_rx, data_os, k % 16, exp_rx, k < 16);
            end
            if (k == 0 || k == 16) begin
                total++;
                if (block_lock !== 2'b11 || sync_err !== 2'b00) begin
                    bad++;
                    $display("FAIL gen4_lock k=%0d got bl=%b se=%b exp bl=11 se=00", k, block_lock, sync_err);
                end
            end
            if (k == 1) begin
                total++;
                if (enable_deskew !== 1'b1) begin
                    bad++;
                    $display("FAIL gen4_deskew got=%b exp=1", enable_deskew);
                end
            end
        end
    endtask

    task automatic test_disable;
        change_gen(2'd2);
        for (int b = 0; b < 4; b++) send_blk(mk2(2'b01, 8'h00), mk2(2'b01, 8'h10), 8);
        lane_rx_enc = {mk2(2'b01, 8'h10), mk2(2'b01, 8'h00)};
        blk_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge enc_clk);
            blk_valid = 1'b0;
        end
        total++;
        if (byte_idx !== 4'd5 || block_lock !== 2'b11) begin
            bad++;
            $display("FAIL dis_pre got idx=%0d bl=%b exp idx=5 bl=11", byte_idx, block_lock);
        end
        enable_dec = 1'b0;
        @(negedge enc_clk);
        total++;
        if (byte_valid !== 1'b0 || lane_rx !== 16'h0 || block_lock !== 2'b00 || blk_ready !== 1'b0) begin
            bad++;
            $display("FAIL dis_flush got bv=%b rx=%h bl=%b rdy=%b exp bv=0 rx=0000 bl=00 rdy=0",
                     byte_valid, lane_rx, block_lock, blk_ready);
        end
        enable_dec = 1'b1;
        @(negedge enc_clk);
        total++;
        if (blk_ready !== 1'b1 || byte_valid !== 1'b0) begin
            bad++;
            $display("FAIL dis_reenable got rdy=%b bv=%b exp rdy=1 bv=0", blk_ready, byte_valid);
        end
        lane_rx_enc = {mk2(2'b01, 8'h88), mk2(2'b01, 8'h80)};
        blk_valid = 1'b1;
        @(negedge enc_clk);
        blk_valid = 1'b0;
        total++;
        if (byte_valid !== 1'b1 || byte_idx !== 4'd0 || lane_rx !== 16'h8880) begin
            bad++;
            $display("FAIL dis_restart got bv=%b idx=%0d rx=%h exp bv=1 idx=0 rx=8880", byte_valid, byte_idx, lane_rx);
        end
        repeat (8) @(negedge enc_clk);
    endtask

    task automatic test_async_reset;
        change_gen(2'd1);
        lane_rx_enc = {mk3(4'b1010, 8'hD0), mk3(4'b1010, 8'hC0)};
        blk_valid = 1'b1;
        @(negedge enc_clk);
        blk_valid = 1'b0;
        repeat (3) @(negedge enc_clk);
        total++;
        if (byte_idx !== 4'd3 || data_os !== 1'b1 || lane_rx !== 16'hD3C3) begin
            bad++;
            $display("FAIL arst_pre got idx=%0d os=%b rx=%h exp idx=3 os=1 rx=d3c3", byte_idx, data_os, lane_rx);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({lane_rx, byte_valid, byte_idx, data_os, sync_err, block_lock, enable_deskew, blk_ready} !== '0) begin
            bad++;
            $display("FAIL arst_outputs got rx=%h bv=%b idx=%0d os=%b se=%b bl=%b ed=%b rdy=%b exp all zero",
                     lane_rx, byte_valid, byte_idx, data_os, sync_err, block_lock, enable_deskew, blk_ready);
        end
        @(negedge enc_clk);
        rst = 1'b1;
        @(negedge enc_clk);
        total++;
        if (blk_ready !== 1'b1 || byte_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_release got rdy=%b bv=%b exp rdy=1 bv=0", blk_ready, byte_valid);
        end
    endtask

    initial begin
        test_reset();
        test_gen2_lock();
        test_gen3_b2b();
        test_gen3_lose_lock();
        test_gen4();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
